floo_wormhole_arbiter: RTL and testbench
========================================

Name: floo_wormhole_arbiter

Overview:
- Per-output-port wormhole arbiter. Sits directly downstream of the per-input route selectors in the router.
- Each input's request is the upstream valid ANDed with that input's one-hot route bit for this output. The block picks one input round-robin and forwards its flits to the output link.
- Once a packet's first flit is accepted, the grant is held until the flit with hdr.last = 1 has been transferred. This keeps wormhole packets contiguous.
- A pending (offered but not yet accepted) output flit is never revoked.

Parameters:
- NumInp, 5, number of requesting input ports (>= 1).
- flit_t, logic, flit type; must contain hdr.last.
- IdxWidth, max(1, $clog2(NumInp)), width of the grant index.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- valid_i  in  NumInp  per-input request (already route-masked upstream).
- ready_o  out  NumInp  per-input accept.
- data_i  in  NumInp x flit_t  per-input flit.
- valid_o  out  1  output flit valid.
- ready_i  in  1  output link ready.
- data_o  out  flit_t  forwarded flit.
- gnt_idx_o  out  IdxWidth  index of the currently selected input.
- locked_o  out  1  high while a packet (or stalled first flit) owns the output.

Behaviour:
- Reset:
  - While rst_ni = 0 at a clock edge, the next state is: state = IDLE, rr_ptr = 0, held_idx = 0.
  - During the cycle(s) rst_ni is low, valid_o = 0, ready_o = 0, data_o = '0, gnt_idx_o = 0, locked_o = 0.
- State: FSM {IDLE, HOLD, LOCKED}, plus registers rr_ptr[IdxWidth] and held_idx[IdxWidth].
- Selection in IDLE (combinational): sel = first i with valid_i[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NumInp (wraps past NumInp-1 to 0).
- Selection in HOLD/LOCKED: sel = held_idx; all other inputs are ignored.
- Outputs:
  - valid_o = valid_i[sel] (in IDLE, = OR of valid_i).
  - data_o = data_i[sel].
  - ready_o[sel] = ready_i; ready_o[j != sel] = 0.
  - gnt_idx_o = sel.
  - locked_o = (state != IDLE).
- Zero-latency combinational path from input to output; no internal buffering.
- Handshake: hs = valid_o & ready_i. Last-flit flag is data_o.hdr.last.
- Transitions from IDLE:
  - No valid input -> stay IDLE.
  - valid_o & !ready_i -> HOLD, held_idx = sel. Guarantees valid/data stability while stalled.
  - hs with last = 0 -> LOCKED, held_idx = sel.
  - hs with last = 1 (single-flit packet) -> stay IDLE, rr_ptr = sel+1 mod NumInp.
- Transitions from HOLD:
  - No hs -> stay HOLD.
  - hs with last = 0 -> LOCKED.
  - hs with last = 1 -> IDLE, rr_ptr = held_idx+1 mod NumInp.
- Transitions from LOCKED:
  - hs with last = 1 -> IDLE, rr_ptr = held_idx+1 mod NumInp.
  - Otherwise stay LOCKED, including when valid_i[held_idx] drops mid-packet (bubble). No other input is served during a bubble.
- rr_ptr only changes on a last-flit handshake, so fairness is per packet, not per flit.
- Back-to-back packets: after a last-flit hs, the next cycle arbitrates in IDLE with the new rr_ptr. No dead cycle.
- Same input requesting again after its last flit has the lowest priority if others request.
- NumInp = 1: rr_ptr stays 0; block degenerates to a pass-through with lock tracking.
- Reset mid-packet: lock and pointer are discarded immediately; the partial packet is not completed by this block.
- Simulation-only assertions (excluded under TARGET_SYNTHESIS):
  - HOLD/LOCKED with valid_i[held_idx] = 0 in HOLD -> error (upstream revoked valid).
  - data_o changes while valid_o & !ready_i -> error.

Test Plan:
- Reset then inputs 1 and 3 both valid, single-flit (last = 1), ready_i = 1 -> grants 1 then 3 then 1 on consecutive cycles; gnt_idx_o = 1, 3, 1; no idle cycle.
- Input 2 sends a 4-flit packet while input 0 requests continuously -> output carries 2,2,2,2 then 0; ready_o[0] = 0 for all 4 cycles; locked_o = 1 for cycles 1-3 of the packet.
- Input 4 valid, ready_i = 0 for 3 cycles, input 0 asserts valid in cycle 2 -> state HOLD; gnt_idx_o stays 4 and data_o is unchanged; transfer of input 4's flit on the first ready cycle.
- Wrap-around: rr_ptr = 4 after serving input 3; inputs 0 and 4 valid -> input 4 wins, then input 0.
- Mid-packet bubble: input 1 packet with valid_i[1] low for 2 cycles between flits 2 and 3, input 3 valid -> valid_o = 0 during the bubble; input 3 is not served until input 1's last flit is transferred.
- Reset asserted in LOCKED (held_idx = 2) -> next cycle state IDLE, rr_ptr = 0; with inputs 0 and 2 valid, input 0 wins.

Source files
------------

// File: rtl/floo_wormhole_arbiter.sv
`default_nettype none
// ============================================================================
// floo_wormhole_arbiter : per-output round-robin arbiter that holds its grant
//                         for a whole wormhole packet (until hdr.last).
// Revision: 1.0
// ============================================================================

package floo_wormhole_pkg;
  typedef struct packed {
    logic last;
  } hdr_t;

  typedef struct packed {
    hdr_t       hdr;
    logic [7:0] payload;
  } flit_t;
endpackage

module floo_wormhole_arbiter #(
  parameter int unsigned NumInp   = 5,
  parameter type         flit_t   = floo_wormhole_pkg::flit_t,
  parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumInp-1:0]   valid_i,
  output logic [NumInp-1:0]   ready_o,
  input  flit_t [NumInp-1:0]  data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output flit_t               data_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output logic                locked_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]          r_state, w_state_next;
  logic [IdxWidth-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [IdxWidth-1:0] r_held_idx, w_held_idx_next;
  logic [IdxWidth-1:0] w_rr_idx, w_sel, w_sel_inc;
  logic [31:0]         w_cand;
  logic                w_any_valid, w_sel_valid, w_hs, w_last;

  // First requester at or after the round-robin pointer, wrapping modulo NumInp.
  always_comb begin : rr_search
    w_rr_idx    = r_rr_ptr;
    w_any_valid = 1'b0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      w_cand = (32'(r_rr_ptr) + k) % NumInp;
      if (!w_any_valid && valid_i[IdxWidth'(w_cand)]) begin
        w_any_valid = 1'b1;
        w_rr_idx    = IdxWidth'(w_cand);
      end
    end
  end

  assign w_sel       = (r_state == ST_IDLE) ? w_rr_idx : r_held_idx;
  assign w_sel_valid = valid_i[w_sel];
  assign w_hs        = w_sel_valid & ready_i;
  assign w_last      = data_i[w_sel].hdr.last;
  assign w_sel_inc   = IdxWidth'((32'(w_sel) + 32'd1) % NumInp);

  always_ff @(posedge clk_i) begin : state_reg
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_held_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_held_idx <= w_held_idx_next;
    end
  end

  // The pointer only moves on a last-flit handshake, so fairness is per packet.
  always_comb begin : next_state
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_held_idx_next = r_held_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          if (w_hs && w_last) begin
            w_rr_ptr_next = w_sel_inc;
          end else begin
            w_state_next    = w_hs ? ST_LOCKED : ST_HOLD;
            w_held_idx_next = w_sel;
          end
        end
      end
      ST_HOLD, ST_LOCKED: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_next  = ST_IDLE;
            w_rr_ptr_next = w_sel_inc;
          end else begin
            w_state_next = ST_LOCKED;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin : outputs
    valid_o   = 1'b0;
    ready_o   = '0;
    data_o    = '0;
    gnt_idx_o = '0;
    locked_o  = 1'b0;
    if (rst_ni) begin
      valid_o        = w_sel_valid;
      ready_o[w_sel] = ready_i;
      data_o         = data_i[w_sel];
      gnt_idx_o      = w_sel;
      locked_o       = (r_state != ST_IDLE);
    end
  end

`ifndef TARGET_SYNTHESIS
  a_hold_valid_kept: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ST_HOLD) |-> valid_i[r_held_idx]);

  a_stalled_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> $stable(data_o));
`endif

endmodule

`default_nettype wire

// File: tb/tb_floo_wormhole_arbiter.sv
`default_nettype none
// ============================================================================
// tb_floo_wormhole_arbiter : scoreboard bench with a packet-level reference model.
// Revision: 1.0
// ============================================================================
module tb_floo_wormhole_arbiter;
  import floo_wormhole_pkg::*;

  localparam int N  = 5;
  localparam int XW = 3 + $bits(flit_t);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  valid_i = '0;
  logic [N-1:0]  ready_o;
  flit_t [N-1:0] data_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  flit_t         data_o;
  logic [2:0]    gnt_idx;
  logic          locked;

  floo_wormhole_arbiter #(.NumInp(N)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .gnt_idx_o (gnt_idx),
    .locked_o  (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         in_rst;
    logic         v;
    logic [N-1:0] rdy;
    logic         lk;
    logic         chk_g;
    logic [2:0]   g;
    flit_t        d;
  } exp_t;

  exp_t            cyc_q[$];
  logic [XW-1:0]   xfer_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;

  // Reference model: current packet owner (-1 = free) and round-robin start.
  int owner = -1;
  int ptr   = 0;
  // Upstream generators: presented flit, flits left in packet, sequence number.
  bit pres[N];
  int rem[N];
  int seq[N];
  // Stimulus knobs.
  logic [N-1:0] en = '0;
  logic [N-1:0] gap = '0;
  logic         rst_drive = 1'b0;
  int           p_valid = 100;
  int           p_ready = 100;
  int           len_fix = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    int   cand;
    @(negedge clk);
    rst_n   = rst_drive;
    ready_i = ($urandom_range(99) < p_ready);
    for (int i = 0; i < N; i++) begin
      if (!rst_drive) begin
        pres[i] = 0;
        rem[i]  = 0;
      end else if (!pres[i] && !gap[i] && (rem[i] > 0 || en[i]) &&
                   $urandom_range(99) < p_valid) begin
        pres[i] = 1;
        if (rem[i] == 0) rem[i] = (len_fix > 0) ? len_fix : int'($urandom_range(4, 1));
      end
      valid_i[i]          = pres[i];
      data_i[i].hdr.last  = (rem[i] == 1);
      data_i[i].payload   = {3'(i), 5'(seq[i])};
    end
    #1;
    e = '0;
    if (!rst_drive) begin
      e.in_rst = 1'b1;
      e.chk_g  = 1'b1;
      owner    = -1;
      ptr      = 0;
    end else begin
      cand = owner;
      if (owner < 0)
        for (int k = 0; k < N; k++)
          if (cand < 0 && valid_i[(ptr + k) % N]) cand = (ptr + k) % N;
      e.lk = (owner >= 0);
      if (cand >= 0) begin
        e.v         = valid_i[cand];
        e.chk_g     = 1'b1;
        e.g         = 3'(cand);
        e.rdy[cand] = ready_i;
        e.d         = data_i[cand];
      end
      if (e.v && ready_i) begin
        xfer_q.push_back({3'(cand), data_i[cand]});
        pres[cand] = 0;
        rem[cand]  = rem[cand] - 1;
        seq[cand]  = seq[cand] + 1;
        if (data_i[cand].hdr.last) begin
          owner = -1;
          ptr   = (cand + 1) % N;
        end else begin
          owner = cand;
        end
      end else if (e.v) begin
        owner = cand;
      end
    end
    cyc_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int n);
    en = '0; gap = '0; p_valid = 100; p_ready = 100;
    cycles(n);
  endtask

  // Monitor: compares every presented cycle and pops the transfer scoreboard on handshakes.
  initial begin
    exp_t          e;
    logic [XW-1:0] x;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        check("valid_o", 32'(valid_o), 32'(e.v));
        check("locked_o", 32'(locked), 32'(e.lk));
        if (e.chk_g) begin
          check("ready_o", 32'(ready_o), 32'(e.rdy));
          check("gnt_idx_o", 32'(gnt_idx), 32'(e.g));
        end
        if (e.v || e.in_rst) check("data_o", 32'(data_o), 32'(e.d));
        if (valid_o && ready_i) begin
          if (xfer_q.size() == 0) begin
            check("xfer_unexpected", 32'(1), 32'(0));
          end else begin
            x = xfer_q.pop_front();
            check("xfer", 32'({gnt_idx, data_o}), 32'(x));
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pres[i] = 0; rem[i] = 0; seq[i] = 0;
    end
    rst_drive = 1'b0;
    cycles(2);
    rst_drive = 1'b1;

    // Inputs 1 and 3 single-flit packets: 1, 3, 1 back to back.
    en = 5'b01010; len_fix = 1; cycles(3); drain(8);

    // Input 2 four-flit packet while input 0 requests continuously.
    en = 5'b00100; len_fix = 4; cycles(1);
    en = 5'b00101; cycles(5); drain(10);

    // Input 4 stalled three cycles, input 0 arrives during the stall.
    len_fix = 1; en = 5'b10000; p_ready = 0; cycles(1);
    en = 5'b10001; cycles(2);
    p_ready = 100; cycles(2); drain(8);

    // Pointer wrap: serve input 3, then inputs 0 and 4 compete.
    en = 5'b01000; len_fix = 1; cycles(1);
    en = 5'b10001; cycles(2); drain(8);

    // Mid-packet bubble on input 1 while input 3 waits.
    en = 5'b00010; len_fix = 4; cycles(1);
    en = 5'b01010; cycles(1);
    gap = 5'b00010; cycles(2);
    gap = 5'b00000; cycles(4); drain(12);

    // Reset while locked on input 2, then inputs 0 and 2 compete.
    en = 5'b00100; len_fix = 4; cycles(2);
    rst_drive = 1'b0; cycles(1);
    rst_drive = 1'b1; en = 5'b00101; len_fix = 1; cycles(2); drain(8);

    // Randomized traffic with random packet lengths.
    len_fix = 0; en = '1; p_valid = 60; p_ready = 70; cycles(300);
    p_valid = 25; p_ready = 40; cycles(300);
    rst_drive = 1'b0; cycles(1);
    rst_drive = 1'b1; p_valid = 80; p_ready = 50; cycles(150);
    drain(40);

    @(negedge clk);
    #3;
    check("scoreboard_empty", 32'(xfer_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
